dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the maximum number of consecutive m0 grants while m1 is waiting (legal range 1..15).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  CPU data-port access request; held until granted.
REQ-005 m0_we  input  1  CPU write (1) / read (0), valid with m0_req.
REQ-006 m0_addr  input  8  CPU word address.
REQ-007 m0_wdata  input  16  CPU write data.
REQ-008 m0_gnt  output  1  CPU request accepted this cycle.
REQ-009 m0_rvalid  output  1  CPU read data valid.
REQ-010 m0_rdata  output  16  CPU read data.
REQ-011 m1_req, m1_we, m1_addr[7:0], m1_wdata[15:0], m1_lock  inputs  host/loader port, same meaning as m0; m1_lock requests exclusive ownership.
REQ-012 m1_gnt, m1_rvalid, m1_rdata[15:0]  outputs  host port, same meaning as m0.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_addr  output  8  memory address.
REQ-016 mem_wdata  output  16  memory write data.
REQ-017 mem_rdata  input  16  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-018 At most one of m0_gnt, m1_gnt SHALL be high in any cycle; grant is combinational from current req and registered state.
REQ-019 In the grant cycle, mem_en=1, mem_we/mem_addr/mem_wdata SHALL equal the granted port's we/addr/wdata; with no grant, mem_en=0, mem_we=0, addr/wdata=0.
REQ-020 Granted read SHALL produce that port's rvalid=1 with rdata=mem_rdata exactly one cycle after the grant; rvalid high for one cycle per read; rdata holds last value otherwise.
REQ-021 Granted write SHALL produce no rvalid.
REQ-022 FSM states: IDLE, SHARE, LOCK1.
REQ-023 IDLE: no request pending; first request moves to SHARE (granted same cycle).
REQ-024 SHARE, single requester: that requester granted.
REQ-025 SHARE, both requesting: m0 granted while streak < STARVE_LIMIT; otherwise m1 granted.
REQ-026 streak (4-bit) SHALL increment on each m0 grant while m1_req=1, saturate at STARVE_LIMIT, clear on any m1 grant or when m1_req=0.
REQ-027 m1 grant with m1_lock=1 SHALL move to LOCK1 next cycle.
REQ-028 LOCK1: only m1 granted (whenever m1_req=1); m0_gnt=0 regardless of m0_req.
REQ-029 LOCK1 exits to SHARE on the first cycle m1_lock=0 (that cycle arbitrated per SHARE rules); lock takes priority over streak.
REQ-030 SHARE returns to IDLE when neither port requests and no read response is outstanding.
REQ-031 Back-to-back grants SHALL be possible every cycle (throughput 1 access/cycle).

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, streak 0, all gnt/rvalid/mem_en/mem_we 0, rdata and mem_addr/mem_wdata 0.
REQ-033 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset release.
REQ-034 First grant possible on the first rising edge cycle after reset deasserts.

Verification
REQ-035 m0 read addr 8'h10 alone, memory holds 16'h1234 -> m0_gnt same cycle, m0_rvalid=1 with m0_rdata=16'h1234 next cycle, m1 outputs 0.
REQ-036 m0 and m1 both request continuously, STARVE_LIMIT=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
REQ-037 m1 write 16'h00FF to 8'h20 with m1_lock=1 for 3 cycles while m0_req=1 -> m0_gnt=0 throughout lock, m0 granted first cycle after m1_lock drops and m1_req=0.
REQ-038 Alternating m0 write 16'hBEEF to 8'h05 then m1 read 8'h05 -> m1_rdata=16'hBEEF one cycle after m1_gnt.
REQ-039 reset pulsed low during granted read -> outputs 0 asynchronously, no rvalid after release, next m0 request granted in first cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/host data-memory ports and shared memory bus
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [7:0]  m0_addr;
   logic [15:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [15:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [7:0]  m1_addr;
   logic [15:0] m1_wdata;
   logic        m1_lock;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [15:0] m1_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with m1 starvation guard and lock
// Grants are combinational; read data is forwarded from mem_rdata in the response cycle.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHARE, LOCK1} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state_q, state_d;
   logic [3:0]  streak_q, streak_d;
   logic        rd0_q, rd0_d;
   logic        rd1_q, rd1_d;
   logic [15:0] hold0_q, hold0_d;
   logic [15:0] hold1_q, hold1_d;
   logic        gnt0, gnt1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         streak_q <= 4'd0;
         rd0_q    <= 1'b0;
         rd1_q    <= 1'b0;
         hold0_q  <= 16'd0;
         hold1_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         rd0_q    <= rd0_d;
         rd1_q    <= rd1_d;
         hold0_q  <= hold0_d;
         hold1_q  <= hold1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;

      // A held lock shuts m0 out entirely; otherwise m0 wins until m1 has waited too long.
      if (state_q == LOCK1 && bus.m1_lock) begin
         gnt1 = bus.m1_req;
      end else if (bus.m0_req && bus.m1_req) begin
         if (streak_q < LIMIT) gnt0 = 1'b1;
         else                  gnt1 = 1'b1;
      end else begin
         gnt0 = bus.m0_req;
         gnt1 = bus.m1_req;
      end

      // Grants are combinational, so reset must mask them directly.
      if (!reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end

      if (gnt1 || !bus.m1_req) begin
         streak_d = 4'd0;
      end else if (gnt0 && streak_q < LIMIT) begin
         streak_d = streak_q + 4'd1;
      end

      if (gnt1 && bus.m1_lock) begin
         state_d = LOCK1;
      end else if (state_q == LOCK1 && bus.m1_lock) begin
         state_d = LOCK1;
      end else if (bus.m0_req || bus.m1_req || rd0_q || rd1_q) begin
         state_d = SHARE;
      end else begin
         state_d = IDLE;
      end

      rd0_d   = gnt0 & ~bus.m0_we;
      rd1_d   = gnt1 & ~bus.m1_we;
      hold0_d = rd0_q ? bus.mem_rdata : hold0_q;
      hold1_d = rd1_q ? bus.mem_rdata : hold1_q;
   end

   assign bus.m0_gnt    = gnt0;
   assign bus.m1_gnt    = gnt1;
   assign bus.mem_en    = gnt0 | gnt1;
   assign bus.mem_we    = gnt0 ? bus.m0_we    : (gnt1 ? bus.m1_we    : 1'b0);
   assign bus.mem_addr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : 8'd0);
   assign bus.mem_wdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : 16'd0);

   assign bus.m0_rvalid = rd0_q;
   assign bus.m1_rvalid = rd1_q;
   assign bus.m0_rdata  = rd0_q ? bus.mem_rdata : hold0_q;
   assign bus.m1_rdata  = rd1_q ? bus.mem_rdata : hold1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter
module tb_dmem_arbiter;

   localparam int LIM = 4;

   logic clock;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [15:0] ram     [0:255];
   logic [15:0] ref_mem [0:255];

   dmem_arbiter_if bus();

   dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'(i) ^ 16'h5A5A;
      ram[8'h10] <= 16'h1234;
   end

   always @(posedge clock) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= ram[bus.mem_addr];
      end
   end

   task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                        input logic l1);
      bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
      bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
      bus.m1_lock = l1;
   endtask

   task automatic test_reset;
      drive(1, 0, 8'h10, 16'h1111, 1, 1, 8'h11, 16'h2222, 1);
      #1;
      n_cmp++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we, bus.m0_rvalid, bus.m1_rvalid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we, bus.m0_rvalid, bus.m1_rvalid});
      end
      n_cmp++;
      if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_membus: got %h required 000000", {bus.mem_addr, bus.mem_wdata});
      end
      n_cmp++;
      if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h required 00000000", {bus.m0_rdata, bus.m1_rdata});
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_single_read;
      @(negedge clock);
      drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, 0);
      #1;
      n_cmp++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 8'h10) begin
         n_fail++;
         $display("FAIL single_grant: got gnt/en/we %b addr %h required 1010 addr 10",
                  {bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr);
      end
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL single_rdata: got rvalid %b rdata %h required 1 1234", bus.m0_rvalid, bus.m0_rdata);
      end
      n_cmp++;
      if ({bus.m1_gnt, bus.m1_rvalid, bus.m1_rdata} !== 18'h0) begin
         n_fail++;
         $display("FAIL single_m1_quiet: got %h required 0", {bus.m1_gnt, bus.m1_rvalid, bus.m1_rdata});
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL single_hold: got rvalid %b rdata %h required 0 1234", bus.m0_rvalid, bus.m0_rdata);
      end
   endtask

   task automatic test_starve;
      int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int got;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         drive(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0, 0);
         #1;
         got = (bus.m0_gnt && !bus.m1_gnt) ? 0 : ((bus.m1_gnt && !bus.m0_gnt) ? 1 : 2);
         n_cmp++;
         if (got !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL starve_seq[%0d]: got winner %0d required %0d", i, got, exp_seq[i]);
         end
      end
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_lock;
      @(negedge clock);
      drive(0, 0, 8'h0, 16'h0, 1, 1, 8'h20, 16'h00FF, 1);
      #1;
      n_cmp++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 3'b011 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 16'h00FF) begin
         n_fail++;
         $display("FAIL lock_first: got gnt/we %b addr %h wdata %h required 011 20 00FF",
                  {bus.m0_gnt, bus.m1_gnt, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         drive(1, 0, 8'h05, 16'h0, (i != 1), 1, 8'h20, 16'h00FF, 1);
         #1;
         n_cmp++;
         if ({bus.m0_gnt, bus.m1_gnt} !== {1'b0, (i != 1)}) begin
            n_fail++;
            $display("FAIL lock_hold[%0d]: got gnt %b required 0%b", i, {bus.m0_gnt, bus.m1_gnt}, (i != 1));
         end
      end
      @(negedge clock);
      drive(1, 0, 8'h05, 16'h0, 0, 0, 8'h0, 16'h0, 0);
      #1;
      n_cmp++;
      if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.mem_addr !== 8'h05) begin
         n_fail++;
         $display("FAIL lock_exit: got gnt %b addr %h required 10 05", {bus.m0_gnt, bus.m1_gnt}, bus.mem_addr);
      end
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (ram[8'h20] !== 16'h00FF) begin
         n_fail++;
         $display("FAIL lock_write: got mem[20] %h required 00FF", ram[8'h20]);
      end
   endtask

   task automatic test_alternate;
      logic [15:0] data;
      logic [7:0]  addr;
      for (int k = 0; k < 3; k++) begin
         data = (k == 0) ? 16'hBEEF : 16'($urandom);
         addr = (k == 0) ? 8'h05 : 8'(8'h40 + k);
         @(negedge clock);
         drive(1, 1, addr, data, 0, 0, 8'h0, 16'h0, 0);
         #1;
         n_cmp++;
         if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 3'b101 || bus.mem_wdata !== data) begin
            n_fail++;
            $display("FAIL alt_write[%0d]: got gnt/we %b wdata %h required 101 %h",
                     k, {bus.m0_gnt, bus.m1_gnt, bus.mem_we}, bus.mem_wdata, data);
         end
         @(negedge clock);
         drive(0, 0, 8'h0, 16'h0, 1, 0, addr, 16'h0, 0);
         #1;
         n_cmp++;
         if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 3'b010 || bus.mem_addr !== addr) begin
            n_fail++;
            $display("FAIL alt_read[%0d]: got gnt/we %b addr %h required 010 %h",
                     k, {bus.m0_gnt, bus.m1_gnt, bus.mem_we}, bus.mem_addr, addr);
         end
         @(negedge clock);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         #1;
         n_cmp++;
         if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== data) begin
            n_fail++;
            $display("FAIL alt_rdata[%0d]: got rvalid %b rdata %h required 1 %h", k, bus.m1_rvalid, bus.m1_rdata, data);
         end
      end
   endtask

   task automatic test_reset_mid_read;
      @(negedge clock);
      drive(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, 0);
      #1;
      n_cmp++;
      if (bus.m0_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_grant: got %b required 1", bus.m0_gnt);
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.m0_gnt, bus.mem_en, bus.m0_rvalid, bus.mem_addr} !== 11'h0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got %h required 0", {bus.m0_gnt, bus.mem_en, bus.m0_rvalid, bus.mem_addr});
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.m0_rvalid, bus.m0_gnt} !== 2'b01 || bus.m0_rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_release: got rvalid/gnt %b rdata %h required 01 0000",
                  {bus.m0_rvalid, bus.m0_gnt}, bus.m0_rdata);
      end
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h1234) begin
         n_fail++;
         $display("FAIL rst_mid_reread: got rvalid %b rdata %h required 1 1234", bus.m0_rvalid, bus.m0_rdata);
      end
   endtask

   task automatic test_random;
      logic        r0, w0, r1, w1, lk;
      logic [7:0]  a0, a1;
      logic [15:0] d0, d1;
      bit          locked;
      int          streak, winner;
      bit          pend0, pend1;
      logic [15:0] pdata0, pdata1, hold0, hold1;
      logic        e_we;
      logic [7:0]  e_addr;
      logic [15:0] e_wdata;

      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
      locked = 0; streak = 0; pend0 = 0; pend1 = 0;
      pdata0 = 0; pdata1 = 0; hold0 = 0; hold1 = 0; lk = 0;

      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         w0 = 1'($urandom);
         w1 = 1'($urandom);
         a0 = 8'($urandom_range(0, 15));
         a1 = 8'($urandom_range(0, 15));
         d0 = 16'($urandom);
         d1 = 16'($urandom);
         lk = lk ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         drive(r0, w0, a0, d0, r1, w1, a1, d1, lk);
         #1;

         n_cmp++;
         if (bus.m0_rvalid !== pend0 || bus.m0_rdata !== (pend0 ? pdata0 : hold0)) begin
            n_fail++;
            $display("FAIL rand_m0_resp[%0d]: got %b %h required %b %h", c, bus.m0_rvalid, bus.m0_rdata,
                     pend0, pend0 ? pdata0 : hold0);
         end
         n_cmp++;
         if (bus.m1_rvalid !== pend1 || bus.m1_rdata !== (pend1 ? pdata1 : hold1)) begin
            n_fail++;
            $display("FAIL rand_m1_resp[%0d]: got %b %h required %b %h", c, bus.m1_rvalid, bus.m1_rdata,
                     pend1, pend1 ? pdata1 : hold1);
         end
         if (pend0) hold0 = pdata0;
         if (pend1) hold1 = pdata1;

         if (locked && lk)   winner = r1 ? 1 : 2;
         else if (r0 && r1)  winner = (streak < LIM) ? 0 : 1;
         else                winner = r0 ? 0 : (r1 ? 1 : 2);

         e_we    = (winner == 0) ? w0 : ((winner == 1) ? w1 : 1'b0);
         e_addr  = (winner == 0) ? a0 : ((winner == 1) ? a1 : 8'h0);
         e_wdata = (winner == 0) ? d0 : ((winner == 1) ? d1 : 16'h0);

         n_cmp++;
         if ({bus.m0_gnt, bus.m1_gnt} !== {winner == 0, winner == 1}) begin
            n_fail++;
            $display("FAIL rand_gnt[%0d]: got %b required %b", c, {bus.m0_gnt, bus.m1_gnt}, {winner == 0, winner == 1});
         end
         n_cmp++;
         if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {winner != 2, e_we, e_addr, e_wdata}) begin
            n_fail++;
            $display("FAIL rand_mem[%0d]: got %h required %h", c,
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {winner != 2, e_we, e_addr, e_wdata});
         end

         pend0 = (winner == 0) && !w0;
         pend1 = (winner == 1) && !w1;
         if (winner != 2) begin
            if (pend0) pdata0 = ref_mem[a0];
            if (pend1) pdata1 = ref_mem[a1];
            if (e_we)  ref_mem[e_addr] = e_wdata;
         end
         locked = ((winner == 1) && lk) || (locked && lk);
         if (winner == 1 || !r1)           streak = 0;
         else if (winner == 0 && streak < LIM) streak++;
      end
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      test_reset;
      test_single_read;
      test_starve;
      test_lock;
      test_alternate;
      test_reset_mid_read;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
